// File: rtl/fetch_pc_unit.sv
// PC register and fetch control for a 256-word instruction ROM.
// FETCH_HALT_ON_ZERO_EN: stop fetching when the ROM returns a zero word.
module fetch_pc_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic [31:0] instruction,
  output logic [7:0]  instruction_address,
  output logic [7:0]  pc_plus1,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        halted,
  output logic        pc_wrapped,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_e;

  state_e      state_q;
  logic [7:0]  pc_q;
  logic [7:0]  pc_d;
  logic [7:0]  seq_pc;
  logic        wrap_q;
  logic [15:0] cnt_q;
  logic        zero_word;
  logic        issue;
  logic        unused_bits;

  assign unused_bits = ^{branch_offset[15:8], jump_target[25:8]};

`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero_word = (instruction == 32'h0);
  assign halted    = (state_q == HALT);
`else
  assign zero_word = 1'b0;
  assign halted    = 1'b0;
`endif

  assign seq_pc = pc_q + 8'd1;
  assign issue  = (state_q == RUN) && !stall && !zero_word;

  assign instruction_address = pc_q;
  assign pc_plus1            = seq_pc;
  assign instr_valid         = issue;
  assign instr_out           = issue ? instruction : 32'h0;
  assign pc_wrapped          = wrap_q;
  assign fetch_count         = cnt_q;

  // Jump beats branch; branch offset is relative to PC+1.
  always_comb begin
    pc_d = seq_pc;
    if (jump) begin
      pc_d = jump_target[7:0];
    end else if (branch_taken) begin
      pc_d = seq_pc + branch_offset[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      wrap_q  <= 1'b0;
      cnt_q   <= 16'h0;
    end else begin
      unique case (state_q)
        IDLE: state_q <= RUN;
        RUN: begin
          if (!stall) begin
            if (zero_word) begin
              state_q <= HALT;
            end else begin
              pc_q <= pc_d;
              if (cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
              end
              if (!jump && !branch_taken && pc_q == 8'hFF) begin
                wrap_q <= 1'b1;
              end
            end
          end
        end
        HALT: state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and fetch-control stage sitting directly upstream of the 256-word instruction ROM. Holds the 8-bit word-addressed PC, drives the ROM address, and forwards the fetched word to decode with a valid qualifier. Selects the next PC from sequential, branch or jump sources supplied by the execute/control logic in the same cycle. Also provides stall handling, an optional halt-on-zero-word stop, and a retired-fetch counter.

## Interface
- `RESET_PC`, default 8'h00, PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC and suppress `instr_valid` this cycle.
- `branch_taken`  in  1  take the branch this cycle.
- `branch_offset`  in  16  signed word offset, relative to PC+1; only bits [7:0] are used.
- `jump`  in  1  take the jump this cycle.
- `jump_target`  in  26  word-address target; only bits [7:0] are used.
- `instruction`  in  32  word returned by the ROM for `instruction_address`.
- `instruction_address`  out  8  current PC, driven straight to the ROM.
- `pc_plus1`  out  8  PC+1 mod 256, used as the link value.
- `instr_out`  out  32  `instruction` when `instr_valid` is 1, else 32'h0 (nop).
- `instr_valid`  out  1  `instr_out` is a real fetch to be executed.
- `halted`  out  1  fetch stopped; cleared only by reset.
- `pc_wrapped`  out  1  sticky flag, set when PC advances sequentially from 255 to 0.
- `fetch_count`  out  16  count of cycles with `instr_valid`=1, saturating.

## Operation
- States:
  - IDLE: one bubble after reset.
  - RUN: normal fetch.
  - HALT: fetch stopped.
- Reset puts the block in IDLE with PC=`RESET_PC`, `pc_wrapped`=0, `fetch_count`=0, `halted`=0, `instr_valid`=0 and `instr_out`=0.
- IDLE goes to RUN on the next edge unconditionally. PC is held in IDLE.
- `instr_valid` = (state==RUN) && !`stall`. `instr_out` is combinational from `instruction`.
- In RUN with `stall`=0, the next PC uses this priority:
  - `jump`: `jump_target[7:0]`.
  - else `branch_taken`: (PC+1+`branch_offset[7:0]`) mod 256.
  - else PC+1 mod 256.
- In RUN with `stall`=1, PC is held and `jump` and `branch_taken` are ignored. The consumer must hold them until the stall clears.
- `pc_wrapped` is set only by the sequential 255→0 step. Branch or jump targets that land on 0 do not set it.
- `fetch_count` increments on each edge where `instr_valid`=1. It sticks at 16'hFFFF.
- HALT holds PC at the halting word's address, forces `instr_valid`=0 and `halted`=1, and ignores all inputs except `rst`.
- `rst` overrides everything in every state, including mid-stall and HALT.

## Timing
- Zero-latency address: `instruction_address` equals the PC register. The ROM returns `instruction` combinationally in the same cycle.
- Control inputs are sampled at the edge that ends the cycle. The new PC is visible the following cycle, so the redirect penalty is zero cycles and there are no delay slots.
- First valid fetch occurs in the second cycle after `rst` deasserts (the IDLE bubble comes first).
- `halted` rises in the cycle after the halting word is presented.

## Configuration
- `FETCH_HALT_ON_ZERO_EN` defined:
  - In RUN with `stall`=0, an `instruction` equal to 32'h0 is not issued: `instr_valid`=0 that cycle.
  - The block enters HALT on the next edge with PC unchanged.
- `FETCH_HALT_ON_ZERO_EN` undefined:
  - 32'h0 is issued as a normal nop and PC advances.
  - The HALT state is unreachable and `halted` is tied to 0.

## Test plan
- Reset then sequential run, with `rst` held for 2 cycles then released:
  - Address sequence 0 (IDLE, valid=0), 0, 1, 2, 3 with valid=1.
  - `fetch_count`=4 after the fourth valid cycle.
- Redirects:
  - At PC=5, `branch_taken`=1 and `branch_offset`=16'h0006 → next address 12.
  - At PC=9, `jump`=1 and `jump_target`=26'h5 → next address 5.
  - `jump` and `branch_taken` both 1 → the jump target wins.
- Stall: `stall`=1 for 3 cycles at PC=7 with `jump`=1 → address stays 7 and `instr_valid`=0 for those 3 cycles. When the stall drops with `jump` still 1 → next address is the jump target.
- Wrap: with `RESET_PC`=8'hFE → addresses FE, FF, 00. `pc_wrapped` rises on the edge into 00 and stays 1 until reset.
- Halt-on-zero (`FETCH_HALT_ON_ZERO_EN` defined), with ROM words 0..13 nonzero and word 14 = 0 → at PC=14, `instr_valid`=0. The next cycle `halted`=1 with address frozen at 14. With the macro undefined, the address advances to 15.
- Reset from HALT or mid-stall → the next cycle shows PC=`RESET_PC`, state IDLE, `halted`=0 and `fetch_count`=0.
